// File: rtl/turn_signal_ctrl.sv
// ---------------------------------------------------------------------------
// turn_signal_ctrl
//
// Upstream controller for the left/right 3-lamp tail-light sequencers.
// Synchronises the four driver switches, divides the board clock into a slow
// step pulse, arbitrates the switches into a single turn mode and tracks the
// 4-position sweep so that a mode change only lands on a sweep boundary.
//
// Parameters
//   TICK_DIV      step period in clk cycles (>= 2)
//
// Ports
//   clk           board clock, all state changes on the rising edge
//   reset         synchronous, active-low reset
//   left_req      asynchronous left-turn switch
//   right_req     asynchronous right-turn switch
//   hazard_req    asynchronous hazard switch
//   brake         asynchronous brake switch
//   step          one-cycle pulse every TICK_DIV cycles (sequencer enable)
//   left_in       turn request to the left sequencer
//   right_in      turn request to the right sequencer
//   left_steady   left lamps on steady for braking
//   right_steady  right lamps on steady for braking
//   mode          0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD
//   phase         sweep position 0..3, mirrors the sequencer state
// ---------------------------------------------------------------------------
module turn_signal_ctrl #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  input  logic       brake,
  output logic       step,
  output logic       left_in,
  output logic       right_in,
  output logic       left_steady,
  output logic       right_steady,
  output logic [1:0] mode,
  output logic [1:0] phase
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } mode_t;

  // Switch vectors are packed as {brake, hazard, right, left}.
  logic [3:0] req_meta;
  logic [3:0] req_sync;
  logic       left_s;
  logic       right_s;
  logic       hazard_s;
  logic       brake_s;

  logic [CW-1:0] cnt;

  mode_t      dreq;
  mode_t      mode_q;
  mode_t      mode_d;
  logic [1:0] phase_q;
  logic [1:0] phase_d;

  // Two-flop synchronisers for the asynchronous driver switches.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_meta <= '0;
      req_sync <= '0;
    end else begin
      req_meta <= {brake, hazard_req, right_req, left_req};
      req_sync <= req_meta;
    end
  end

  assign left_s   = req_sync[0];
  assign right_s  = req_sync[1];
  assign hazard_s = req_sync[2];
  assign brake_s  = req_sync[3];

  // Step prescaler: free-running 0..TICK_DIV-1 counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Decoded from the register so step is glitch-free and aligned with cnt.
  assign step = (cnt == CNT_MAX);

  // Request arbitration: hazard wins, and both turn switches together are
  // treated as hazard rather than picking a side.
  always_comb begin
    dreq = IDLE;
    if (hazard_s || (left_s && right_s)) begin
      dreq = HAZARD;
    end else if (left_s) begin
      dreq = LEFT;
    end else if (right_s) begin
      dreq = RIGHT;
    end
  end

  // Mode/phase state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q  <= IDLE;
      phase_q <= 2'd0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
    end
  end

  // Next-state logic. A new mode is only accepted from IDLE or on the step
  // that finishes phase 3, so a started sweep always runs to completion.
  // Entering a turn mode from IDLE does not advance phase on that edge
  // because the phase advance looks at the current (IDLE) mode.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    if (step) begin
      if (mode_q == IDLE || phase_q == 2'd3) begin
        mode_d = dreq;
      end
      if (mode_q != IDLE) begin
        phase_d = phase_q + 2'd1;
      end
    end
    if (mode_d == IDLE) begin
      phase_d = 2'd0;
    end
  end

  // Outputs come straight off the mode register with no extra stage.
  assign mode     = mode_q;
  assign phase    = phase_q;
  assign left_in  = (mode_q == LEFT)  || (mode_q == HAZARD);
  assign right_in = (mode_q == RIGHT) || (mode_q == HAZARD);

  // Steady brake lamps only on a side that is not sweeping; hazard keeps
  // both sides flashing even while braking.
  assign left_steady  = brake_s && !left_in  && (mode_q != HAZARD);
  assign right_steady = brake_s && !right_in && (mode_q != HAZARD);

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_turn_signal_ctrl
//
// Directed bench for turn_signal_ctrl with TICK_DIV = 4. A cycle-level model
// of the controller built from elapsed-cycle arithmetic is checked against
// the DUT on every falling edge, and literal expectations at key cycles pin
// the model's behaviour.
// ---------------------------------------------------------------------------
module tb_turn_signal_ctrl;

  localparam int unsigned TICK_DIV = 4;

  logic       clk;
  logic       reset;
  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic       brake;
  logic       step;
  logic       left_in;
  logic       right_in;
  logic       left_steady;
  logic       right_steady;
  logic [1:0] mode;
  logic [1:0] phase;

  int vectors;
  int miscompares;

  turn_signal_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .left_req     (left_req),
    .right_req    (right_req),
    .hazard_req   (hazard_req),
    .brake        (brake),
    .step         (step),
    .left_in      (left_in),
    .right_in     (right_in),
    .left_steady  (left_steady),
    .right_steady (right_steady),
    .mode         (mode),
    .phase        (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: cycles elapsed since the last reset edge, two-deep switch
  // history, and the current mode / sweep position as plain integers.
  bit       mValid;
  int       mCycles;
  int       mMode;
  int       mPhase;
  bit [3:0] mFirst;
  bit [3:0] mSecond;
  bit       expStep;
  bit       expLeftIn;
  bit       expRightIn;
  bit       expLeftSteady;
  bit       expRightSteady;

  always @(posedge clk) begin
    int  dreq;
    int  oldMode;
    bit  stepNow;
    if (!reset) begin
      mValid  = 1'b1;
      mCycles = 0;
      mMode   = 0;
      mPhase  = 0;
      mFirst  = '0;
      mSecond = '0;
    end else begin
      stepNow = (mCycles % TICK_DIV) == (TICK_DIV - 1);
      if (mSecond[2] || (mSecond[0] && mSecond[1])) dreq = 3;
      else if (mSecond[0]) dreq = 1;
      else if (mSecond[1]) dreq = 2;
      else dreq = 0;
      oldMode = mMode;
      if (stepNow && (oldMode == 0 || mPhase == 3)) mMode = dreq;
      if (stepNow && oldMode != 0) mPhase = (mPhase + 1) % 4;
      mCycles = mCycles + 1;
      mSecond = mFirst;
      mFirst  = {brake, hazard_req, right_req, left_req};
    end
    expStep        = (mCycles % TICK_DIV) == (TICK_DIV - 1);
    expLeftIn      = (mMode == 1) || (mMode == 3);
    expRightIn     = (mMode == 2) || (mMode == 3);
    expLeftSteady  = mSecond[3] && !expLeftIn && (mMode != 3);
    expRightSteady = mSecond[3] && !expRightIn && (mMode != 3);
  end

  task automatic checkOutput(input string name, input logic [1:0] act,
                             input logic [1:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic h,
                               input logic b);
    left_req   = l;
    right_req  = r;
    hazard_req = h;
    brake      = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("step",         {1'b0, step},         {1'b0, expStep});
      checkOutput("left_in",      {1'b0, left_in},      {1'b0, expLeftIn});
      checkOutput("right_in",     {1'b0, right_in},     {1'b0, expRightIn});
      checkOutput("left_steady",  {1'b0, left_steady},  {1'b0, expLeftSteady});
      checkOutput("right_steady", {1'b0, right_steady}, {1'b0, expRightSteady});
      checkOutput("mode",         mode,                 mModeBits());
      checkOutput("phase",        phase,                mPhaseBits());
    end
  end

  function automatic logic [1:0] mModeBits();
    return 2'(mMode);
  endfunction

  function automatic logic [1:0] mPhaseBits();
    return 2'(mPhase);
  endfunction

  initial begin
    logic [31:0] r;
    vectors     = 0;
    miscompares = 0;
    mValid      = 1'b0;
    reset       = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Reset hold for 3 cycles with every switch on.
    tick(3);
    checkOutput("hold step",     {1'b0, step},         2'd0);
    checkOutput("hold mode",     mode,                 2'd0);
    checkOutput("hold phase",    phase,                2'd0);
    checkOutput("hold left_in",  {1'b0, left_in},      2'd0);
    checkOutput("hold right_in", {1'b0, right_in},     2'd0);
    checkOutput("hold lsteady",  {1'b0, left_steady},  2'd0);
    checkOutput("hold rsteady",  {1'b0, right_steady}, 2'd0);

    // Release with only left requested; this is cycle 0.
    $display("[TB] left from idle");
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("c2 step",       {1'b0, step},     2'd0);
    tick(1);
    checkOutput("c3 step",       {1'b0, step},     2'd1);
    checkOutput("c3 mode",       mode,             2'd0);
    tick(1);
    checkOutput("c4 mode",       mode,             2'd1);
    checkOutput("c4 left_in",    {1'b0, left_in},  2'd1);
    checkOutput("c4 right_in",   {1'b0, right_in}, 2'd0);
    checkOutput("c4 phase",      phase,            2'd0);
    tick(3);
    checkOutput("c7 step",       {1'b0, step},     2'd1);
    tick(1);
    checkOutput("c8 phase",      phase,            2'd1);

    // Direction change mid-sweep at phase 1.
    $display("[TB] direction change");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(3);
    checkOutput("c11 step",      {1'b0, step},     2'd1);
    tick(1);
    checkOutput("c12 phase",     phase,            2'd2);
    checkOutput("c12 left_in",   {1'b0, left_in},  2'd1);
    tick(7);
    checkOutput("c19 phase",     phase,            2'd3);
    checkOutput("c19 left_in",   {1'b0, left_in},  2'd1);
    checkOutput("c19 mode",      mode,             2'd1);
    tick(1);
    checkOutput("c20 mode",      mode,             2'd2);
    checkOutput("c20 right_in",  {1'b0, right_in}, 2'd1);
    checkOutput("c20 left_in",   {1'b0, left_in},  2'd0);
    checkOutput("c20 phase",     phase,            2'd0);

    // Both sides requested: hazard at the end of the right sweep.
    $display("[TB] both sides");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick(15);
    checkOutput("c35 mode",      mode,             2'd2);
    checkOutput("c35 phase",     phase,            2'd3);
    tick(1);
    checkOutput("c36 mode",      mode,             2'd3);
    checkOutput("c36 left_in",   {1'b0, left_in},  2'd1);
    checkOutput("c36 right_in",  {1'b0, right_in}, 2'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick(2);
    checkOutput("c38 lsteady",   {1'b0, left_steady},  2'd0);
    checkOutput("c38 rsteady",   {1'b0, right_steady}, 2'd0);
    tick(6);
    checkOutput("c44 mode",      mode,             2'd3);
    checkOutput("c44 phase",     phase,            2'd2);

    // One-cycle reset during hazard at phase 2.
    $display("[TB] reset mid-sequence");
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    checkOutput("rst mode",      mode,                 2'd0);
    checkOutput("rst phase",     phase,                2'd0);
    checkOutput("rst step",      {1'b0, step},         2'd0);
    checkOutput("rst left_in",   {1'b0, left_in},      2'd0);
    checkOutput("rst right_in",  {1'b0, right_in},     2'd0);
    checkOutput("rst lsteady",   {1'b0, left_steady},  2'd0);
    checkOutput("rst rsteady",   {1'b0, right_steady}, 2'd0);

    // Brake in IDLE, then in LEFT.
    $display("[TB] brake");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("b1 lsteady",    {1'b0, left_steady},  2'd0);
    tick(1);
    checkOutput("b2 step",       {1'b0, step},         2'd0);
    checkOutput("b2 lsteady",    {1'b0, left_steady},  2'd1);
    checkOutput("b2 rsteady",    {1'b0, right_steady}, 2'd1);
    tick(1);
    checkOutput("b3 step",       {1'b0, step},         2'd1);
    tick(1);
    checkOutput("b4 mode",       mode,                 2'd1);
    checkOutput("b4 lsteady",    {1'b0, left_steady},  2'd0);
    checkOutput("b4 rsteady",    {1'b0, right_steady}, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(2);
    checkOutput("b6 rsteady",    {1'b0, right_steady}, 2'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1);
    checkOutput("b7 rsteady",    {1'b0, right_steady}, 2'd0);
    tick(1);
    checkOutput("b8 rsteady",    {1'b0, right_steady}, 2'd1);
    checkOutput("b8 lsteady",    {1'b0, left_steady},  2'd0);

    // Assorted switch patterns held a few cycles each, checked by the model.
    $display("[TB] mixed patterns");
    for (int i = 0; i < 15; i++) begin
      r = $urandom;
      applyStimulus(r[0], r[1], r[2] & r[5], r[3]);
      tick(5);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick(20);
    checkOutput("end mode",      mode,                 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Upstream controller for the tail-light sequencers. It synchronises the driver switches (left, right, hazard, brake) and divides the board clock into a slow step pulse that clocks the sequencers. It arbitrates the switches into one turn mode and drives the per-side `in` request to the left and right 3-lamp sequencers. A mode change is allowed only at a sequence boundary, so a sweep that has started always completes.

## Interface
- `TICK_DIV`, default 12_500_000: step period in `clk` cycles (4 Hz at 50 MHz); legal range ≥ 2.
- `clk`  in  1  board clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `left_req`  in  1  asynchronous left-turn switch.
- `right_req`  in  1  asynchronous right-turn switch.
- `hazard_req`  in  1  asynchronous hazard switch.
- `brake`  in  1  asynchronous brake switch.
- `step`  out  1  one-cycle pulse every `TICK_DIV` cycles; sequencer clock enable.
- `left_in`  out  1  turn request to the left sequencer.
- `right_in`  out  1  turn request to the right sequencer.
- `left_steady`  out  1  left lamps on steady (brake).
- `right_steady`  out  1  right lamps on steady (brake).
- `mode`  out  2  current mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD.
- `phase`  out  2  sequence position 0..3, mirrors the 4-state sequencer.

## Operation
- **Synchronisers.** Each request passes through 2 flops. `left_s`, `right_s`, `hazard_s` and `brake_s` are the second-stage values.
- **Prescaler.** `cnt` counts 0..TICK_DIV-1, then wraps to 0.
  - `step = (cnt == TICK_DIV-1)`, decoded from the register.
- **Decoded request `dreq`:**
  - HAZARD if `hazard_s | (left_s & right_s)`.
  - else LEFT if `left_s`.
  - else RIGHT if `right_s`.
  - else IDLE.
- **Mode FSM** (states IDLE, LEFT, RIGHT, HAZARD):
  - On an edge with `step`=1 and (`mode`==IDLE or `phase`==3): `mode <= dreq`.
  - Otherwise `mode` holds.
  - Withdrawing a request mid-sequence does not stop the sweep; it ends at the phase-3 step.
- **Phase counter:**
  - On `step` with `mode`≠IDLE: `phase <= phase+1` mod 4 (3→0 wraps).
  - In IDLE, `phase` is held at 0.
  - Entering a turn mode from IDLE leaves `phase` at 0 on that edge.
- **Outputs** are decoded from the `mode` register, with no extra stage:
  - `left_in` = `mode`∈{LEFT, HAZARD}.
  - `right_in` = `mode`∈{RIGHT, HAZARD}.
- **Brake:**
  - `left_steady = brake_s & ~left_in & (mode≠HAZARD)`.
  - `right_steady = brake_s & ~right_in & (mode≠HAZARD)`.
  - HAZARD suppresses steady brake on both sides.
- **Reset** (`reset`=0 at an edge): `cnt`=0, synchronisers=0, `mode`=IDLE, `phase`=0.
  - Every output is 0 on the following cycle.
  - Reset overrides a coincident `step` and is allowed mid-sequence.

## Timing
- `step` first goes high in cycle TICK_DIV-1 after the first edge that samples `reset`=1. It then recurs every TICK_DIV cycles.
- Switch to synchronised value: 2 edges.
- Request to `left_in`/`right_in`: 2 sync edges, plus a wait for the next qualifying `step` edge.
  - From IDLE, worst case is 2+TICK_DIV cycles.
  - Mid-sequence, up to 4·TICK_DIV cycles.
- Brake to `*_steady`: 2 edges, with no step alignment.
- Simultaneous request change and a qualifying `step`: the mode update uses the `dreq` value present in that cycle.

## Test plan
Run all scenarios with TICK_DIV=4.
- **Reset hold.** Hold `reset`=0 for 3 cycles with all requests at 1.
  - Required: all outputs 0 while reset is held.
  - After release: `step`=1 in cycles 3, 7 and 11.
- **Left from idle.** Assert `left_req` at release.
  - Required: `mode`=1 and `left_in`=1 after the step at cycle 3.
  - `phase` reads 0→1→2→3→0 on successive steps.
  - `right_in` stays 0.
- **Direction change mid-sweep.** While in LEFT at `phase`=1, drop `left_req` and raise `right_req`.
  - Required: `left_in` stays 1 until the step where `phase`=3.
  - Then `mode`=2, `right_in`=1, `left_in`=0, `phase`=0.
- **Both sides requested.** Assert `left_req` and `right_req` together.
  - Required: `mode`=3 and `left_in`=`right_in`=1.
  - With `brake`=1 added: `left_steady`=`right_steady`=0.
- **Brake.** With `brake`=1 in LEFT: `right_steady`=1 and `left_steady`=0 within 2 cycles.
  - In IDLE, both steady outputs are 1.
- **Reset mid-sequence.** Pull `reset`=0 for 1 cycle during HAZARD at `phase`=2.
  - Required: next cycle `mode`=0, `phase`=0, all outputs 0.
  - `step` restarts 4 cycles after release.
